// File: rtl/uart_rx_byte.sv
// uart_rx_byte: serial byte receiver for an idle-high asynchronous line.
// Receives 8N1 frames by default; define UART_RX_PARITY_EN to receive 8E1
// frames and drive o_parity_err. Every decision is taken on the output of a
// two-flop synchronizer, sampling at the middle of each bit period.
module uart_rx_byte #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  // Terminal counts: the counter starts at 0 on state entry, so the sample
  // edge is the one on which the counter holds N-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic             rx_meta_q;
  logic             rx_s_q;
  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic [7:0]       data_q,    data_d;
  logic             valid_q,   valid_d;
  logic             ferr_q,    ferr_d;
`ifdef UART_RX_PARITY_EN
  logic             par_mis_q, par_mis_d;
  logic             perr_q,    perr_d;
`endif

  // Two-flop synchronizer for the asynchronous line; resets to idle (high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Next-state logic: frame sequencing, bit sampling and one-cycle pulses.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_mis_d = par_mis_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          // A start bit that is gone by its midpoint was only a glitch.
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          // Even parity: data bits plus parity bit must XOR to zero.
          par_mis_d = rx_s_q ^ (^shift_q);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // Leaving at the stop midpoint keeps back-to-back frames intact.
          if (!rx_s_q) begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_mis_q) begin
            perr_d  = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        // Hold off until the line is released so a stuck-low line is one error.
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Receiver state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mis_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_mis_q <= par_mis_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: bench for uart_rx_byte. Honours UART_RX_PARITY_EN.
module tb_uart_rx_byte;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int NB  = 10;
`else
  localparam bit PAR = 1'b0;
  localparam int NB  = 9;
`endif
  // Start edge -> rx_s (2) -> START entry (1) -> stop sample -> pulse visible.
  localparam int LAT = 3 + HALF + NB * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_parity_err;
  logic       o_busy;

  uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_parity_err(o_parity_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observed events: {kind, byte} with kind 0=valid, 1=frame err, 2=parity err.
  int unsigned cyc = 0;
  int unsigned last_valid_cyc = 0;
  int unsigned frame_start_cyc = 0;
  logic [9:0]  obs_q[$];
  logic [9:0]  exp_q[$];
  logic [7:0]  model_data = 8'h00;
  int          overlap_cnt = 0;
  int          double_cnt = 0;
  int          stable_viol = 0;
  logic        prev_pulse = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  int          npulse;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    npulse = int'(o_valid) + int'(o_frame_err) + int'(o_parity_err);
    if (npulse > 1) overlap_cnt++;
    if (npulse > 0 && prev_pulse) double_cnt++;
    prev_pulse = (npulse > 0);
    if (o_valid) begin
      obs_q.push_back({2'd0, o_data});
      last_valid_cyc = cyc;
    end else if (o_frame_err) begin
      obs_q.push_back({2'd1, 8'h00});
    end else if (o_parity_err) begin
      obs_q.push_back({2'd2, 8'h00});
    end
    if (rst_n && !o_valid && (o_data !== prev_data)) stable_viol++;
    prev_data = o_data;
  end

  task automatic drive_bit(input logic v);
    i_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame and records what the receiver must report for it.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    frame_start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR) drive_bit(par_bit);
    drive_bit(stop_bit);
    if (!stop_bit) begin
      exp_q.push_back({2'd1, 8'h00});
    end else if (PAR && (par_bit != ^b)) begin
      exp_q.push_back({2'd2, 8'h00});
    end else begin
      exp_q.push_back({2'd0, b});
      model_data = b;
    end
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_evt%0d", tag, i), obs_q[i], exp_q[i]);
    check({tag, "_data"}, o_data, model_data);
    check({tag, "_busy"}, o_busy, 1'b0);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int         busy_cnt;
    logic [7:0] b;
    logic       bad_stop, bad_par;

    rst_n = 1'b0;
    i_rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", o_data, 8'h00);
    check("rst_valid", o_valid, 1'b0);
    check("rst_ferr", o_frame_err, 1'b0);
    check("rst_perr", o_parity_err, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    rst_n = 1'b1;
    idle(5);

    // Single frame plus its output latency.
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle(2 * CPB);
    compare_events("a5");
    check("a5_latency", last_valid_cyc - frame_start_cyc, LAT);

    // Back-to-back frames with one stop bit each.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(2 * CPB);
    compare_events("b2b");

    // Short low glitch on an idle line.
    busy_cnt = 0;
    i_rx = 1'b0;
    for (int i = 0; i < 33; i++) begin
      if (i == 3) i_rx = 1'b1;
      if (o_busy) busy_cnt++;
      @(negedge clk);
    end
    check("glitch_busy_seen", busy_cnt > 0, 1'b1);
    check("glitch_busy_le7", busy_cnt <= 7, 1'b1);
    compare_events("glitch");

    // Stop bit low with the line held low, then a normal frame.
    send_frame(8'h55, 1'b0, ^8'h55);
    repeat (50 - CPB) @(negedge clk);
    idle(2 * CPB);
    compare_events("brk");
    send_frame(8'h12, 1'b1, ^8'h12);
    idle(2 * CPB);
    compare_events("after_brk");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2 * CPB);
    compare_events("par_bad");
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2 * CPB);
    compare_events("par_good");
`endif

    // Reset during data bit 4.
    b = 8'h9A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    i_rx = b[4];
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", o_data, 8'h00);
    check("mid_rst_valid", o_valid, 1'b0);
    check("mid_rst_ferr", o_frame_err, 1'b0);
    check("mid_rst_perr", o_parity_err, 1'b0);
    check("mid_rst_busy", o_busy, 1'b0);
    model_data = 8'h00;
    i_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    compare_events("post_rst");
    send_frame(8'hC3, 1'b1, ^8'hC3);
    idle(2 * CPB);
    compare_events("c3");

    // Randomized traffic with occasional bad stop and bad parity bits.
    for (int k = 0; k < 24; k++) begin
      b        = 8'($urandom);
      bad_stop = ($urandom_range(0, 7) == 0);
      bad_par  = PAR && ($urandom_range(0, 5) == 0);
      send_frame(b, !bad_stop, (^b) ^ bad_par);
      if (bad_stop) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        idle(CPB);
      end else begin
        idle($urandom_range(0, 12));
      end
    end
    idle(2 * CPB);
    compare_events("rand");

    check("no_overlap", overlap_cnt, 0);
    check("single_cycle_pulses", double_cnt, 0);
    check("data_stable", stable_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Byte receiver for the board's RS232 input line (pin61), the receive-side counterpart of the serial transmit path driven on pin58. It samples the asynchronous serial line, detects 8N1 frames (optionally 8E1), and presents each received byte with a one-cycle valid strobe. The top level routes its outputs to the lamp bank and 7-segment logic. Error pulses are available for buzzer or LED indication.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz
- BAUD, 9600, line bit rate
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_rx  input  1  serial line, idle high, asynchronous to clk
- o_data  output  8  last correctly received byte, LSB = first data bit
- o_valid  output  1  one-cycle pulse; o_data updated in the same cycle
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low
- o_parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without parity feature)
- o_busy  output  1  high from start-bit detection until return to IDLE

## Operation
- CLKS_PER_BIT = CLK_HZ / BAUD (integer truncation); HALF = CLKS_PER_BIT / 2. CLKS_PER_BIT must be ≥ 4; the bit-period counter is sized to $clog2(CLKS_PER_BIT).
- i_rx passes through a 2-flop synchronizer (reset to 1). All decisions use the synchronized value rx_s.
- States:
  - IDLE: rx_s==0 → START, clear counter.
  - START: after HALF cycles, sample. rx_s==1 → IDLE (glitch; no output pulse). rx_s==0 → DATA, bit index 0.
  - DATA: every CLKS_PER_BIT cycles, sample into shift register, LSB first. After the 8th sample → PARITY if enabled, otherwise STOP.
  - PARITY: after CLKS_PER_BIT cycles, sample. Compare against even parity of the 8 data bits and latch the mismatch flag.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - rx_s==1 and no parity mismatch: o_data ← shift register, o_valid pulse, → IDLE.
    - rx_s==1 with parity mismatch: o_parity_err pulse, o_data unchanged, → IDLE.
    - rx_s==0: o_frame_err pulse, o_data unchanged, → BREAK.
  - BREAK: wait until rx_s==1, then → IDLE. This prevents a held-low line from producing repeated frames.
- Frame and parity error on the same frame: only o_frame_err pulses.
- Return to IDLE at the stop-bit midpoint, so back-to-back frames with a single stop bit are received without loss.
- o_busy = (state != IDLE).

## Timing
- Reset values: o_data=8'h00, o_valid=0, o_frame_err=0, o_parity_err=0, o_busy=0, state IDLE, synchronizer flops = 1.
- Synchronizer latency is 2 cycles from an i_rx edge to rx_s.
- Start detection: o_busy rises 1 cycle after rx_s first reads 0.
- Sample points fall HALF + k·CLKS_PER_BIT cycles after entering START, where k=1..8 are the data bits, k=9 is parity or stop, and k=10 is stop when parity is enabled.
- o_valid / error pulses assert exactly 1 cycle after the stop sample edge. They are never asserted together and never for more than 1 cycle.
- rst_n asserted mid-frame: immediate return to reset values. A partially received byte is discarded. After release, a line that is still low is treated as a new start.
- o_data is stable between o_valid pulses.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state is compiled in and the frame is 8E1 (11 bits). o_parity_err is live.
- UART_RX_PARITY_EN undefined: the PARITY state is absent and the frame is 8N1 (10 bits). o_parity_err is driven constant 0.

## Test plan
- Bench parameters: CLK_HZ=1_000_000, BAUD=100_000 (CLKS_PER_BIT=10, HALF=5).
- Send 8'hA5, 8N1 → one o_valid pulse, o_data=8'hA5, no error pulses, o_busy low afterwards.
- Send 8'h00, 8'hFF, 8'h3C back-to-back with one stop bit each → three o_valid pulses in order, each reporting the correct byte.
- Drive a 3-cycle low glitch on idle i_rx → no pulses; o_busy high for at most ~7 cycles, then IDLE.
- Send 8'h55 with the stop bit forced low, holding the line low for 50 cycles → one o_frame_err pulse, o_data retains its previous value. A following 8'h12 is received correctly after the line returns high.
- With UART_RX_PARITY_EN: send 8'h07 with parity bit 0 (wrong; even parity requires 1) → o_parity_err pulse, no o_valid. Repeat with parity 1 → o_valid, o_data=8'h07.
- Assert rst_n low during data bit 4 of a frame → all outputs 0 immediately. A subsequent full 8'hC3 frame is received correctly.
